// File: rtl/gb_mem_map.sv
// gb_mem_map: sm83 memory map with boot-ROM overlay, MBC1-style banking, WRAM/echo and HRAM.
// Read data is registered; memories are not cleared by reset and may be preloaded at any time.
module gb_mem_map #(
  parameter int ROM_BANKS  = 64,
  parameter int RAM_BANKS  = 4,
  parameter int BOOT_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        write,
  output logic [7:0]  rdata,
  output logic        io_sel,
  input  logic        load_we,
  input  logic        load_boot,
  input  logic [22:0] load_addr,
  input  logic [7:0]  load_data
);
  localparam int RB        = $clog2(ROM_BANKS);
  localparam int RW        = RB + 14;
  localparam int ROM_BYTES = ROM_BANKS * 16384;
  localparam int BW        = $clog2(BOOT_BYTES);
  localparam int RAM_DEPTH = (RAM_BANKS == 4) ? 32768 : 8192;
  localparam int EW        = $clog2(RAM_DEPTH);
  logic [7:0] boot_mem [BOOT_BYTES];
  logic [7:0] cart_mem [ROM_BYTES];
  logic [7:0] eram     [RAM_DEPTH];
  logic [7:0] wram     [8192];
  logic [7:0] hram     [127];
  logic [7:0] rdata_q, rdata_d;
  logic [4:0] lo_q, lo_d;
  logic [1:0] hi_q, hi_d;
  logic       mode_q, mode_d, ram_en_q, ram_en_d, boot_en_q, boot_en_d;
  logic [RB-1:0] bn, b0;
  logic [RW-1:0] rom_idx;
  logic [EW-1:0] ram_idx;
  logic in_boot, in_eram, in_wram, in_hram, eram_ok;
  assign bn      = RB'({hi_q, lo_q});
  assign b0      = RB'(mode_q ? {hi_q, 5'd0} : 7'd0);
  assign rom_idx = {addr[14] ? bn : b0, addr[13:0]};
  assign ram_idx = EW'({(mode_q && RAM_BANKS == 4) ? hi_q : 2'd0, addr[12:0]});
  assign in_boot = boot_en_q && (32'(addr) < BOOT_BYTES);
  assign in_eram = addr[15:13] == 3'b101;
  assign in_wram = addr >= 16'hC000 && addr < 16'hFE00;
  assign in_hram = addr[15:7] == 9'h1FF && addr != 16'hFFFF;
  assign eram_ok = ram_en_q && RAM_BANKS != 0;
  assign io_sel  = (addr[15:7] == 9'h1FE && addr != 16'hFF50) || addr == 16'hFFFF;
  assign rdata   = rdata_q;
  always_comb begin
    rdata_d = 8'hFF;
    if (in_boot) rdata_d = boot_mem[addr[BW-1:0]];
    else if (!addr[15]) rdata_d = cart_mem[rom_idx];
    else if (in_eram) rdata_d = eram_ok ? eram[ram_idx] : 8'hFF;
    else if (in_wram) rdata_d = wram[addr[12:0]];
    else if (in_hram) rdata_d = hram[addr[6:0]];
  end
  always_comb begin
    lo_d      = lo_q;
    hi_d      = hi_q;
    mode_d    = mode_q;
    ram_en_d  = ram_en_q;
    boot_en_d = boot_en_q && !(write && addr == 16'hFF50 && wdata != 8'h00);
    if (write && !addr[15]) begin
      case (addr[14:13])
        2'd0:    ram_en_d = wdata[3:0] == 4'hA;
        2'd1:    lo_d = (wdata[4:0] == 5'd0) ? 5'd1 : wdata[4:0];
        2'd2:    hi_d = wdata[1:0];
        default: mode_d = wdata[0];
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q   <= 8'h00;
      lo_q      <= 5'd1;
      hi_q      <= 2'd0;
      mode_q    <= 1'b0;
      ram_en_q  <= 1'b0;
      boot_en_q <= 1'b1;
    end else begin
      rdata_q   <= rdata_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      mode_q    <= mode_d;
      ram_en_q  <= ram_en_d;
      boot_en_q <= boot_en_d;
    end
  end
  // Storage has no reset so contents survive a mid-program reset.
  always_ff @(posedge clk) begin
    if (load_we && load_boot && 32'(load_addr) < BOOT_BYTES) boot_mem[load_addr[BW-1:0]] <= load_data;
    if (load_we && !load_boot && 32'(load_addr) < ROM_BYTES) cart_mem[load_addr[RW-1:0]] <= load_data;
    if (write && in_eram && eram_ok) eram[ram_idx] <= wdata;
    if (write && in_wram) wram[addr[12:0]] <= wdata;
    if (write && in_hram) hram[addr[6:0]] <= wdata;
  end
endmodule
